tos_stack: RTL and testbench

- Parametrised top-of-stack-cached hardware stack for the next-generation j1 core.
- One instance serves as the data stack and one as the return stack.
- Top lives in a register; deeper entries live in a 2**DEPTH-entry RAM addressed by a circular pointer.
- Adds what the current stack lacks: signed pointer deltas, occupancy tracking, sticky overflow/underflow flags, selectable wrap/block mode and a registered debug peek port.

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_ram.sv | 35 +++
 rtl/tos_stack.sv | 168 ++++++++++++++++
 tb/tb_tos_stack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the j1 top-of-stack-cached stacks.
// Holds the op_delta encodings and the default word width and pointer width
// used by the core when it builds its data and return stacks.
package stack_pkg;

  localparam int STACK_WIDTH = 16;
  localparam int STACK_DEPTH = 5;

  // The two-bit delta is a signed pointer step: +1 push, -1 pop, -2 drop-two.
  typedef enum logic [1:0] {
    DELTA_NONE  = 2'b00,
    DELTA_PUSH  = 2'b01,
    DELTA_DROP2 = 2'b10,
    DELTA_POP   = 2'b11
  } delta_e;

endpackage

// File: rtl/stack_ram.sv
// Storage for the entries below top.
// Ports:
//   clock      - write clock, rising edge
//   we_i       - write enable
//   waddr_i    - write address
//   wdata_i    - write data
//   raddr_a_i  - read port A address (next), rdata_a_o asynchronous data
//   raddr_b_i  - read port B address (peek), rdata_b_o asynchronous data
// Contents are deliberately not reset.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 5
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [DEPTH-1:0] raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [DEPTH-1:0] raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH)-1];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/tos_stack.sv
// Top-of-stack-cached hardware stack. Top is held in a register, deeper
// entries live in a circular RAM addressed by a wrapping pointer.
// Ports:
//   clock, active_low_reset     - clock and async active-low reset
//   op_valid, op_delta          - apply op this cycle; none/push/pop/drop-two
//   top_next                    - value top takes when the op is applied
//   top, next                   - top register; entry under top (0 if empty)
//   occupancy                   - number of valid RAM entries
//   overflow, underflow         - sticky error flags, cleared by flag_clear
//   peek_request, peek_index    - debug read of entry peek_index below top
//   peek_data, peek_valid       - registered peek result and its strobe
module tos_stack
  import stack_pkg::*;
#(
  parameter int WIDTH          = STACK_WIDTH,
  parameter int DEPTH          = STACK_DEPTH,
  parameter int BLOCK_ON_ERROR = 0
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             op_valid,
  input  logic [1:0]       op_delta,
  input  logic [WIDTH-1:0] top_next,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [DEPTH:0]   occupancy,
  output logic             overflow,
  output logic             underflow,
  input  logic             flag_clear,
  input  logic             peek_request,
  input  logic [DEPTH-1:0] peek_index,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid
);

  localparam logic [DEPTH-1:0] PTR_ONE  = DEPTH'(1);
  localparam logic [DEPTH-1:0] PTR_TWO  = DEPTH'(2);
  localparam logic [DEPTH:0]   OCC_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   OCC_TWO  = (DEPTH+1)'(2);
  localparam logic [DEPTH:0]   OCC_FULL = {1'b1, {DEPTH{1'b0}}};
  localparam logic             BLOCKING = (BLOCK_ON_ERROR != 0);

  logic [DEPTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [DEPTH:0]   occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] peek_data_q;
  logic             peek_valid_q;

  logic             ovf_err, unf_err;
  logic             push_wr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_next, ram_peek;
  logic [DEPTH-1:0] peek_addr;
  logic             peek_hit;

  always_comb begin
    ptr_d   = ptr_q;
    top_d   = top_q;
    occ_d   = occ_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;
    push_wr = 1'b0;
    if (op_valid) begin
      unique case (delta_e'(op_delta))
        DELTA_NONE: top_d = top_next;
        DELTA_PUSH: begin
          if (occ_q == OCC_FULL) begin
            ovf_err = 1'b1;
            // Wrap mode overwrites the oldest slot, which is ptr+1 when full.
            if (!BLOCKING) begin
              push_wr = 1'b1;
              ptr_d   = ptr_q + PTR_ONE;
              top_d   = top_next;
            end
          end else begin
            push_wr = 1'b1;
            ptr_d   = ptr_q + PTR_ONE;
            top_d   = top_next;
            occ_d   = occ_q + OCC_ONE;
          end
        end
        DELTA_POP: begin
          if (occ_q == '0) begin
            unf_err = 1'b1;
            if (!BLOCKING) begin
              ptr_d = ptr_q - PTR_ONE;
              top_d = top_next;
            end
          end else begin
            ptr_d = ptr_q - PTR_ONE;
            top_d = top_next;
            occ_d = occ_q - OCC_ONE;
          end
        end
        DELTA_DROP2: begin
          if (occ_q < OCC_TWO) begin
            unf_err = 1'b1;
            if (!BLOCKING) begin
              ptr_d = ptr_q - PTR_TWO;
              top_d = top_next;
              occ_d = '0;
            end
          end else begin
            ptr_d = ptr_q - PTR_TWO;
            top_d = top_next;
            occ_d = occ_q - OCC_TWO;
          end
        end
        default: ;
      endcase
    end
    // A new error outranks a simultaneous clear.
    ovf_d = ovf_err | (ovf_q & ~flag_clear);
    unf_d = unf_err | (unf_q & ~flag_clear);
  end

  // Gate the write with reset so an op in flight when reset asserts is lost.
  assign ram_we    = push_wr & active_low_reset;
  assign peek_addr = ptr_q - peek_index;
  assign peek_hit  = ({1'b0, peek_index} < occ_q);

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock     (clock),
    .we_i      (ram_we),
    .waddr_i   (ptr_q + PTR_ONE),
    .wdata_i   (top_q),
    .raddr_a_i (ptr_q),
    .rdata_a_o (ram_next),
    .raddr_b_i (peek_addr),
    .rdata_b_o (ram_peek)
  );

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      ptr_q        <= '0;
      top_q        <= '0;
      occ_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      peek_data_q  <= '0;
      peek_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      top_q        <= top_d;
      occ_q        <= occ_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      peek_valid_q <= peek_request;
      if (peek_request) begin
        peek_data_q <= peek_hit ? ram_peek : '0;
      end
    end
  end

  assign top        = top_q;
  assign next       = (occ_q != '0) ? ram_next : '0;
  assign occupancy  = occ_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign peek_data  = peek_data_q;
  assign peek_valid = peek_valid_q;

endmodule

// File: tb/tb_tos_stack.sv
`timescale 1ns/1ps
module tb_tos_stack;
  import stack_pkg::*;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         active_low_reset = 1'b0;
  logic         op_valid = 1'b0;
  logic [1:0]   op_delta = 2'b00;
  logic [W-1:0] top_next = '0;
  logic         flag_clear = 1'b0;
  logic         peek_request = 1'b0;
  logic [4:0]   peek_index = '0;

  logic [W-1:0] top0, next0, pd0;
  logic [5:0]   occ0;
  logic         ovf0, unf0, pv0;
  logic [W-1:0] top1, next1, pd1;
  logic [2:0]   occ1;
  logic         ovf1, unf1, pv1;
  logic [W-1:0] top2, next2, pd2;
  logic [2:0]   occ2;
  logic         ovf2, unf2, pv2;

  tos_stack #(.WIDTH(W), .DEPTH(5), .BLOCK_ON_ERROR(0)) u_dut0 (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid),
    .op_delta(op_delta), .top_next(top_next), .top(top0), .next(next0),
    .occupancy(occ0), .overflow(ovf0), .underflow(unf0), .flag_clear(flag_clear),
    .peek_request(peek_request), .peek_index(peek_index), .peek_data(pd0),
    .peek_valid(pv0));

  tos_stack #(.WIDTH(W), .DEPTH(2), .BLOCK_ON_ERROR(0)) u_dut1 (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid),
    .op_delta(op_delta), .top_next(top_next), .top(top1), .next(next1),
    .occupancy(occ1), .overflow(ovf1), .underflow(unf1), .flag_clear(flag_clear),
    .peek_request(peek_request), .peek_index(peek_index[1:0]), .peek_data(pd1),
    .peek_valid(pv1));

  tos_stack #(.WIDTH(W), .DEPTH(2), .BLOCK_ON_ERROR(1)) u_dut2 (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid),
    .op_delta(op_delta), .top_next(top_next), .top(top2), .next(next2),
    .occupancy(occ2), .overflow(ovf2), .underflow(unf2), .flag_clear(flag_clear),
    .peek_request(peek_request), .peek_index(peek_index[1:0]), .peek_data(pd2),
    .peek_valid(pv2));

  always #5 clock = ~clock;

  // Reference model: each stack is a plain list, element 0 is the entry under top.
  int           depth_m [3] = '{5, 2, 2};
  int           boe_m   [3] = '{0, 0, 1};
  logic [W-1:0] m_stk   [3][32];
  int           m_sz    [3];
  logic [W-1:0] m_top   [3];
  logic [W-1:0] m_pd    [3];
  logic         m_ovf   [3];
  logic         m_unf   [3];
  logic         m_pv    [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sz[k] = 0; m_top[k] = '0; m_pd[k] = '0;
      m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_pv[k] = 1'b0;
    end
  endtask

  task automatic list_push(input int k);
    for (int i = 31; i > 0; i--) m_stk[k][i] = m_stk[k][i-1];
    m_stk[k][0] = m_top[k];
  endtask

  task automatic list_pop(input int k, input int n);
    for (int i = 0; i < 32 - n; i++) m_stk[k][i] = m_stk[k][i+n];
  endtask

  task automatic model_step(input int k);
    int  cap, idx;
    logic e_o, e_u;
    cap = 1 << depth_m[k];
    e_o = 1'b0; e_u = 1'b0;
    if (peek_request) begin
      idx = (k == 0) ? int'(peek_index) : int'(peek_index[1:0]);
      m_pd[k] = (idx < m_sz[k]) ? m_stk[k][idx] : '0;
    end
    m_pv[k] = peek_request;
    if (op_valid) begin
      case (op_delta)
        2'b00: m_top[k] = top_next;
        2'b01: begin
          if (m_sz[k] == cap) begin
            e_o = 1'b1;
            if (boe_m[k] == 0) begin list_push(k); m_top[k] = top_next; end
          end else begin
            list_push(k); m_sz[k]++; m_top[k] = top_next;
          end
        end
        2'b11: begin
          if (m_sz[k] == 0) begin
            e_u = 1'b1;
            if (boe_m[k] == 0) m_top[k] = top_next;
          end else begin
            list_pop(k, 1); m_sz[k]--; m_top[k] = top_next;
          end
        end
        default: begin
          if (m_sz[k] < 2) begin
            e_u = 1'b1;
            if (boe_m[k] == 0) begin m_sz[k] = 0; m_top[k] = top_next; end
          end else begin
            list_pop(k, 2); m_sz[k] -= 2; m_top[k] = top_next;
          end
        end
      endcase
    end
    m_ovf[k] = e_o | (m_ovf[k] & ~flag_clear);
    m_unf[k] = e_u | (m_unf[k] & ~flag_clear);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge active_low_reset);
      if (!active_low_reset) model_reset();
      else for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [W-1:0] t, input logic [W-1:0] n,
                          input int occ, input logic ov, input logic un,
                          input logic [W-1:0] pd, input logic pv);
    chk("top", k, 32'(t), 32'(m_top[k]));
    chk("next", k, 32'(n), (m_sz[k] > 0) ? 32'(m_stk[k][0]) : 32'd0);
    chk("occupancy", k, occ, m_sz[k]);
    chk("overflow", k, 32'(ov), 32'(m_ovf[k]));
    chk("underflow", k, 32'(un), 32'(m_unf[k]));
    chk("peek_data", k, 32'(pd), 32'(m_pd[k]));
    chk("peek_valid", k, 32'(pv), 32'(m_pv[k]));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (active_low_reset) begin
        cmp_inst(0, top0, next0, int'(occ0), ovf0, unf0, pd0, pv0);
        cmp_inst(1, top1, next1, int'(occ1), ovf1, unf1, pd1, pv1);
        cmp_inst(2, top2, next2, int'(occ2), ovf2, unf2, pd2, pv2);
      end
    end
  end

  task automatic cyc(input logic v, input logic [1:0] d, input logic [W-1:0] tn,
                     input logic fc, input logic pr, input logic [4:0] pi);
    op_valid = v; op_delta = d; top_next = tn;
    flag_clear = fc; peek_request = pr; peek_index = pi;
    @(posedge clock); #1;
    op_valid = 1'b0; flag_clear = 1'b0; peek_request = 1'b0;
  endtask

  task automatic pulse_reset();
    active_low_reset = 1'b0;
    @(posedge clock); #1;
    active_low_reset = 1'b1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_top"}, 0, 32'(top0), 0);  chk({tag, "_occ"}, 0, 32'(occ0), 0);
    chk({tag, "_next"}, 0, 32'(next0), 0); chk({tag, "_flags"}, 0, {ovf0, unf0, pv0}, 0);
    chk({tag, "_pd"}, 0, 32'(pd0), 0);
    chk({tag, "_top"}, 1, 32'(top1), 0);  chk({tag, "_occ"}, 1, 32'(occ1), 0);
    chk({tag, "_flags"}, 1, {ovf1, unf1, pv1}, 0);
    chk({tag, "_top"}, 2, 32'(top2), 0);  chk({tag, "_occ"}, 2, 32'(occ2), 0);
    chk({tag, "_flags"}, 2, {ovf2, unf2, pv2}, 0);
  endtask

  initial begin
    int r;
    logic [1:0] d;
    repeat (2) @(posedge clock);
    #1;
    all_zero("reset");
    active_low_reset = 1'b1;

    // Basic push/pop.
    cyc(1, DELTA_PUSH, 16'h1111, 0, 0, 0);
    cyc(1, DELTA_PUSH, 16'h2222, 0, 0, 0);
    cyc(1, DELTA_PUSH, 16'h3333, 0, 0, 0);
    chk("lit_top", 0, 32'(top0), 32'h3333);
    chk("lit_next", 0, 32'(next0), 32'h2222);
    chk("lit_occ", 0, 32'(occ0), 3);
    chk("lit_flags", 0, {ovf0, unf0}, 0);
    cyc(1, DELTA_POP, 16'h2222, 0, 0, 0);
    cyc(1, DELTA_POP, 16'h1111, 0, 0, 0);
    chk("lit_top", 0, 32'(top0), 32'h1111);
    chk("lit_occ", 0, 32'(occ0), 1);
    chk("lit_next", 0, 32'(next0), 0);
    cyc(1, DELTA_POP, 16'h0000, 0, 0, 0);
    chk("lit_occ", 0, 32'(occ0), 0);
    chk("lit_unf", 0, 32'(unf0), 0);

    // Overflow in wrap and block modes.
    for (int i = 1; i <= 6; i++) cyc(1, DELTA_PUSH, W'(i), 0, 0, 0);
    chk("lit_occ", 1, 32'(occ1), 4);  chk("lit_ovf", 1, 32'(ovf1), 1);
    chk("lit_top", 1, 32'(top1), 6);  chk("lit_next", 1, 32'(next1), 5);
    chk("lit_occ", 2, 32'(occ2), 4);  chk("lit_ovf", 2, 32'(ovf2), 1);
    chk("lit_top", 2, 32'(top2), 4);
    chk("lit_occ", 0, 32'(occ0), 6);  chk("lit_ovf", 0, 32'(ovf0), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, DELTA_NONE, 0, 0, 1, 5'(i));
      chk("lit_peek", 1, 32'(pd1), 5 - i);
      chk("lit_peek", 2, 32'(pd2), 3 - i);
      chk("lit_pv", 1, 32'(pv1), 1);
    end
    cyc(1, DELTA_PUSH, 16'hBEEF, 0, 0, 0);
    chk("lit_blk_top", 2, 32'(top2), 4);
    chk("lit_blk_occ", 2, 32'(occ2), 4);
    chk("lit_blk_ovf", 2, 32'(ovf2), 1);
    chk("lit_wrap_top", 1, 32'(top1), 32'hBEEF);
    for (int i = 0; i < 4; i++) begin
      cyc(0, DELTA_NONE, 0, 0, 1, 5'(i));
      chk("lit_blk_peek", 2, 32'(pd2), 3 - i);
    end

    // Underflow and flag-clear priority.
    pulse_reset();
    cyc(1, DELTA_PUSH, 16'h0042, 0, 0, 0);
    cyc(1, DELTA_DROP2, 16'h0077, 0, 0, 0);
    chk("lit_unf", 0, 32'(unf0), 1);
    chk("lit_unf", 2, 32'(unf2), 1);
    chk("lit_blk_occ", 2, 32'(occ2), 1);
    chk("lit_blk_top", 2, 32'(top2), 32'h0042);
    cyc(1, DELTA_POP, 16'h0088, 1, 0, 0);
    chk("lit_unf_win", 0, 32'(unf0), 1);
    chk("lit_unf_win", 1, 32'(unf1), 1);
    cyc(0, DELTA_NONE, 0, 1, 0, 0);
    chk("lit_unf_clr", 0, 32'(unf0), 0);
    chk("lit_unf_clr", 1, 32'(unf1), 0);

    // Reset in the middle of a push.
    op_valid = 1'b1; op_delta = DELTA_PUSH; top_next = 16'hA5A5;
    #2;
    active_low_reset = 1'b0;
    #1;
    all_zero("midrst");
    @(posedge clock); #1;
    op_valid = 1'b0;
    active_low_reset = 1'b1;
    chk("post_rst_occ", 0, 32'(occ0), 0);
    chk("post_rst_next", 0, 32'(next0), 0);

    // Randomized traffic, push-biased then pop-biased.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset();
      r = $urandom_range(0, 99);
      if (i < 1500) d = (r < 55) ? DELTA_PUSH : (r < 80) ? DELTA_POP : (r < 90) ? DELTA_DROP2 : DELTA_NONE;
      else          d = (r < 30) ? DELTA_PUSH : (r < 65) ? DELTA_POP : (r < 85) ? DELTA_DROP2 : DELTA_NONE;
      cyc($urandom_range(0, 9) != 0, d, W'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
    end

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
